// File: rtl/pipe_adder_nbit.sv
// pipe_adder_nbit: pipelined ripple-carry adder/subtractor with valid/ready streaming.
//
// One CHUNK-bit slice of the sum is resolved per register stage. The pipeline has
// LAT = WIDTH/CHUNK stages, and every stage advances together.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   A/B/cin/sub carry a transaction
//   in_ready   pipeline can take a transaction this cycle
//   A, B       WIDTH-bit operands
//   cin        carry in; used in add mode only
//   sub        0: S = A + B + cin; 1: S = A - B
//   out_valid  S/cout/ovf carry a result
//   out_ready  consumer takes the result this cycle
//   S          sum or difference, modulo 2^WIDTH
//   cout       carry out of the MSB (in sub mode, 1 means no borrow)
//   ovf        two's-complement signed overflow
module pipe_adder_nbit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LAT = WIDTH / CHUNK;

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $fatal(1, "pipe_adder_nbit: WIDTH must be a multiple of CHUNK");
    end

    // The whole pipe moves as one unit. Bubbles are never squeezed out.
    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int unsigned Lo = k * CHUNK;

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   sum;
        logic [WIDTH-1:0] s_d;

        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_head
            // Subtraction is done as A + ~B + 1, so B is inverted once on entry.
            assign a_in = A;
            assign b_in = sub ? ~B : B;
            assign s_in = '0;
            assign c_in = sub | cin;
            assign v_in = in_valid;
        end else begin : g_body
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        assign sum = {1'b0, a_in[Lo +: CHUNK]} + {1'b0, b_in[Lo +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_in};

        // Lower chunks pass through unchanged. This stage fills in its own chunk.
        always_comb begin
            s_d               = s_in;
            s_d[Lo +: CHUNK]  = sum[CHUNK-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                a_q <= a_in;
                b_q <= b_in;
                s_q <= s_d;
                c_q <= sum[CHUNK];
                v_q <= v_in;
            end
        end
    end

    // The carry into the MSB is recovered from the MSB sum bit:
    // s = a ^ b ^ c, so c = s ^ a ^ b.
    logic c_msb;
    logic ovf_q;
    assign c_msb = g_stage[LAT-1].sum[CHUNK-1] ^ g_stage[LAT-1].a_in[WIDTH-1]
                 ^ g_stage[LAT-1].b_in[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= c_msb ^ g_stage[LAT-1].sum[CHUNK];
        end
    end

    assign out_valid = g_stage[LAT-1].v_q;
    assign S         = g_stage[LAT-1].s_q;
    assign cout      = g_stage[LAT-1].c_q;
    assign ovf       = ovf_q;

    // Nothing downstream reads the operands held in the last stage.
    logic unused_last_ops;
    assign unused_last_ops = ^{g_stage[LAT-1].a_q, g_stage[LAT-1].b_q};

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// tb_pipe_adder_nbit: self-checking bench for pipe_adder_nbit (WIDTH=16, CHUNK=4).
// Stimulus pushes expected results into a queue. A separate monitor pops and compares them
// whenever the DUT hands off a result.
module tb_pipe_adder_nbit;

    localparam int W   = 16;
    localparam int C   = 4;
    localparam int LAT = W / C;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         cout;
    logic         ovf;

    res_t sb[$];
    res_t mon_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipe_adder_nbit #(
        .WIDTH(W),
        .CHUNK(C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Golden model: plain integer arithmetic and sign rules.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic is_sub);
        res_t         r;
        logic [W:0]   full;
        if (is_sub) begin
            full = {1'b0, a} - {1'b0, b};
            r.c  = (a >= b);
            r.s  = full[W-1:0];
            r.o  = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r.c  = full[W];
            r.s  = full[W-1:0];
            r.o  = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
        end
        return r;
    endfunction

    // Call this at the drive point (#1 after posedge). It returns at the next drive point
    // after the transaction is accepted, with in_valid still high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic is_sub, input res_t exp);
        bit done = 1'b0;
        A = a; B = b; cin = ci; sub = is_sub; in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("send_accepted", done, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: compares every result the DUT hands off.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", out_valid, 0);
            end else begin
                mon_exp = sb.pop_front();
                check("S", S, mon_exp.s);
                check("cout", cout, mon_exp.c);
                check("ovf", ovf, mon_exp.o);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           accepted;
        int           cyc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         rc;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Carry ripples through every chunk. Also measure the latency.
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, res_t'{s: 16'h0000, c: 1'b1, o: 1'b0});
        in_valid = 1'b0;
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, LAT);
        @(posedge clk); #1;

        // Directed results: signed overflow, subtract with borrow, subtract without borrow.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, res_t'{s: 16'h8000, c: 1'b0, o: 1'b1});
        send(16'h0005, 16'h0007, 1'b0, 1'b1, res_t'{s: 16'hFFFE, c: 1'b0, o: 1'b0});
        send(16'h0007, 16'h0005, 1'b1, 1'b1, res_t'{s: 16'h0002, c: 1'b1, o: 1'b0});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, res_t'{s: 16'h7FFF, c: 1'b1, o: 1'b1});
        drain();

        // Backpressure: fill the pipe, stall for 5 cycles, then release.
        out_ready = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(1));
            rc = 1'($urandom_range(1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_S", S, sb[0].s);
            check("stall_cout", cout, sb[0].c);
            check("stall_ovf", ovf, sb[0].o);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("resume_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        drain();

        // Random stream with random in_valid and out_ready, in both modes.
        accepted = 0;
        cyc      = 0;
        while (accepted < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(3) != 0);
            A         = W'($urandom);
            B         = W'($urandom);
            cin       = 1'($urandom_range(1));
            sub       = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B, cin, sub));
                accepted++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_count", accepted, 1000);
        drain();

        // Reset in mid-operation with 3 transactions in flight and the output stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        in_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
        end
        check("pre_reset_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_S", S, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        sb.delete();
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            check("no_stale_valid", out_valid, 0);
        end
        @(posedge clk); #1;

        // The pipe still works after the reset.
        send(16'h1234, 16'h4321, 1'b1, 1'b0, res_t'{s: 16'h5556, c: 1'b0, o: 1'b0});
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
